// File: rtl/up_copy_engine.sv
// Word-granular memory copy engine: reads a source word, writes it to the destination, repeats.
// Optional abort input is enabled by defining UP_COPY_ABORT_EN.
module up_copy_engine #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int SIZE_WIDTH = 16
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic [ADDR_WIDTH-1:0] src_addr_i,
  input  logic [ADDR_WIDTH-1:0] dst_addr_i,
  input  logic [SIZE_WIDTH-1:0] size_i,
  input  logic                  int_en_i,
  input  logic                  trigger_pulse_i,
  input  logic                  clr_int_pulse_i,
`ifdef UP_COPY_ABORT_EN
  input  logic                  abort_pulse_i,
`endif
  output logic                  status_busy_o,
  output logic                  status_int_pending_o,
  output logic                  int_o,
  output logic                  mem_req_o,
  input  logic                  mem_gnt_i,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic                  mem_we_o,
  output logic [3:0]            mem_be_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  input  logic                  mem_rvalid_i
);

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    WR_REQ,
    WR_WAIT,
    DONE
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] src_q, src_d;
  logic [ADDR_WIDTH-1:0] dst_q, dst_d;
  logic [SIZE_WIDTH-2:0] cnt_q, cnt_d;
  logic [1:0]            rem_q, rem_d;
  logic [DATA_WIDTH-1:0] buf_q, buf_d;
  logic                  intPend_q, intPend_d;
  logic                  abort_q, abort_d;

  logic [SIZE_WIDTH:0]   sizeRound;
  logic [SIZE_WIDTH-2:0] wordCount;
  logic                  lastWord;
  logic [3:0]            lastBe;
  logic                  abortReq;
  logic                  unusedBits;

  // Rounding up to whole words needs one extra bit so the largest byte count cannot overflow.
  assign sizeRound  = {1'b0, size_i} + (SIZE_WIDTH+1)'(3);
  assign wordCount  = sizeRound[SIZE_WIDTH:2];
  assign lastWord   = (cnt_q == (SIZE_WIDTH-1)'(1));
  assign unusedBits = ^{src_addr_i[1:0], dst_addr_i[1:0], sizeRound[1:0]};

`ifdef UP_COPY_ABORT_EN
  assign abortReq = abort_pulse_i;
`else
  assign abortReq = 1'b0;
`endif

  always_comb begin
    unique case (rem_q)
      2'd1:    lastBe = 4'b0001;
      2'd2:    lastBe = 4'b0011;
      2'd3:    lastBe = 4'b0111;
      default: lastBe = 4'b1111;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    dst_d       = dst_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    buf_d       = buf_q;
    abort_d     = abort_q;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_be_o    = 4'b0000;
    mem_addr_o  = '0;
    mem_wdata_o = '0;

    unique case (state_q)
      IDLE: begin
        if (trigger_pulse_i) begin
          src_d   = {src_addr_i[ADDR_WIDTH-1:2], 2'b00};
          dst_d   = {dst_addr_i[ADDR_WIDTH-1:2], 2'b00};
          cnt_d   = wordCount;
          rem_d   = size_i[1:0];
          abort_d = 1'b0;
          state_d = (size_i == '0) ? DONE : RD_REQ;
        end
      end
      // An abort that coincides with the grant must still wait for that response.
      RD_REQ: begin
        mem_req_o  = 1'b1;
        mem_be_o   = 4'b1111;
        mem_addr_o = src_q;
        if (mem_gnt_i) begin
          state_d = RD_WAIT;
          if (abortReq) abort_d = 1'b1;
        end else if (abortReq) begin
          state_d = DONE;
        end
      end
      RD_WAIT: begin
        if (abortReq) abort_d = 1'b1;
        if (mem_rvalid_i) begin
          buf_d   = mem_rdata_i;
          state_d = (abort_q || abortReq) ? DONE : WR_REQ;
        end
      end
      WR_REQ: begin
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_be_o    = lastWord ? lastBe : 4'b1111;
        mem_addr_o  = dst_q;
        mem_wdata_o = buf_q;
        if (mem_gnt_i) begin
          state_d = WR_WAIT;
          if (abortReq) abort_d = 1'b1;
        end else if (abortReq) begin
          state_d = DONE;
        end
      end
      WR_WAIT: begin
        if (abortReq) abort_d = 1'b1;
        if (mem_rvalid_i) begin
          if (lastWord || abort_q || abortReq) begin
            state_d = DONE;
          end else begin
            src_d   = src_q + ADDR_WIDTH'(4);
            dst_d   = dst_q + ADDR_WIDTH'(4);
            cnt_d   = cnt_q - (SIZE_WIDTH-1)'(1);
            state_d = RD_REQ;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Completion has priority over a clear arriving on the same edge.
  always_comb begin
    intPend_d = intPend_q;
    if (state_q == DONE) begin
      intPend_d = 1'b1;
    end else if (clr_int_pulse_i) begin
      intPend_d = 1'b0;
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q   <= IDLE;
      src_q     <= '0;
      dst_q     <= '0;
      cnt_q     <= '0;
      rem_q     <= '0;
      buf_q     <= '0;
      intPend_q <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      buf_q     <= buf_d;
      intPend_q <= intPend_d;
      abort_q   <= abort_d;
    end
  end

  assign status_busy_o        = (state_q != IDLE);
  assign status_int_pending_o = intPend_q;
  assign int_o                = intPend_q & int_en_i;

endmodule

// File: tb/tb_up_copy_engine.sv
// Self-checking bench for up_copy_engine: randomized memory responder plus a copy-level reference model.
`timescale 1ns/1ps
module tb_up_copy_engine;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 16;

  logic          ACLK = 1'b0;
  logic          ARESET = 1'b1;
  logic [AW-1:0] src_addr_i = '0;
  logic [AW-1:0] dst_addr_i = '0;
  logic [SW-1:0] size_i = '0;
  logic          int_en_i = 1'b0;
  logic          trigger_pulse_i = 1'b0;
  logic          clr_int_pulse_i = 1'b0;
`ifdef UP_COPY_ABORT_EN
  logic          abort_pulse_i = 1'b0;
`endif
  logic          status_busy_o, status_int_pending_o, int_o;
  logic          mem_req_o, mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [3:0]    mem_be_o;
  logic [DW-1:0] mem_wdata_o;
  logic          mem_gnt_i = 1'b0;
  logic          mem_rvalid_i = 1'b0;
  logic [DW-1:0] mem_rdata_i = '0;

  up_copy_engine #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SIZE_WIDTH(SW)) dut (
    .ACLK                 (ACLK),
    .ARESET               (ARESET),
    .src_addr_i           (src_addr_i),
    .dst_addr_i           (dst_addr_i),
    .size_i               (size_i),
    .int_en_i             (int_en_i),
    .trigger_pulse_i      (trigger_pulse_i),
    .clr_int_pulse_i      (clr_int_pulse_i),
`ifdef UP_COPY_ABORT_EN
    .abort_pulse_i        (abort_pulse_i),
`endif
    .status_busy_o        (status_busy_o),
    .status_int_pending_o (status_int_pending_o),
    .int_o                (int_o),
    .mem_req_o            (mem_req_o),
    .mem_gnt_i            (mem_gnt_i),
    .mem_addr_o           (mem_addr_o),
    .mem_we_o             (mem_we_o),
    .mem_be_o             (mem_be_o),
    .mem_wdata_o          (mem_wdata_o),
    .mem_rdata_i          (mem_rdata_i),
    .mem_rvalid_i         (mem_rvalid_i)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } txn_t;

  int errors = 0;
  int checks = 0;

  logic [31:0] mem [0:1023];
  bit          memInit = 0;

  int gntMax = 0;
  int rvMin  = 1;
  int rvMax  = 1;

  // Reference model: copy phase (0 idle, 1 copying, 2 done cycle), expected bus traffic and result.
  int          mPhase = 0;
  bit          mPend = 0;
  bit          mAbortPend = 0;
  int          mWritesLeft = 0;
  int          mWords = 0;
  logic [31:0] mDst = '0;
  logic [31:0] expDst [0:63];
  txn_t        expQ [$];

  // Responder bookkeeping.
  bit          outstanding = 0;
  bit          lastWasWrite = 0;
  int          rvCnt = 0;
  int          gntWait = 0;
  bit          haveReq = 0;
  logic [68:0] capReq = '0;
  logic [31:0] respData = '0;
  int          numReads = 0;
  int          numWrites = 0;
  int          busyCycles = 0;
  int          reqCycles = 0;
  logic [31:0] lastRdAddr = '0;
  logic [31:0] lastWrAddr = '0;
  logic [3:0]  lastWrBe = '0;

  task automatic checkOutput(input string name, input logic [71:0] actual, input logic [71:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Model update on each edge, using the inputs the DUT samples on that edge.
  always @(posedge ACLK) begin
    bit          setNow;
    int          words;
    logic [31:0] sa, da, sw, ow, ew;
    logic [3:0]  be;
    txn_t        t;
    if (ARESET) begin
      mPhase = 0;
      mPend = 0;
      mAbortPend = 0;
      expQ.delete();
    end else begin
      setNow = (mPhase == 2);
      if (mPhase == 2) begin
        mPhase = 0;
      end else if (mPhase == 0) begin
        if (trigger_pulse_i) begin
          words = (int'(size_i) + 3) / 4;
          expQ.delete();
          mWords = words;
          mDst = {dst_addr_i[31:2], 2'b00};
          for (int i = 0; i < words; i++) begin
            sa = {src_addr_i[31:2], 2'b00} + 32'(4 * i);
            da = mDst + 32'(4 * i);
            sw = mem[sa[11:2]];
            ow = mem[da[11:2]];
            if (i == words - 1 && size_i[1:0] != 2'd0) be = 4'((1 << size_i[1:0]) - 1);
            else be = 4'hF;
            for (int b = 0; b < 4; b++)
              ew[8*b +: 8] = (4 * i + b < int'(size_i)) ? sw[8*b +: 8] : ow[8*b +: 8];
            if (i < 64) expDst[i] = ew;
            t.addr = sa; t.we = 1'b0; t.be = 4'hF; t.wdata = '0;
            expQ.push_back(t);
            t.addr = da; t.we = 1'b1; t.be = be; t.wdata = sw;
            expQ.push_back(t);
          end
          mWritesLeft = words;
          mAbortPend = 0;
          mPhase = (words == 0) ? 2 : 1;
        end
      end else begin
`ifdef UP_COPY_ABORT_EN
        if (abort_pulse_i) begin
          if (outstanding || mem_rvalid_i) mAbortPend = 1;
          else mPhase = 2;
        end
`endif
        if (mPhase == 1 && mem_rvalid_i) begin
          if (mAbortPend) begin
            mPhase = 2;
          end else if (lastWasWrite) begin
            mWritesLeft--;
            if (mWritesLeft == 0) mPhase = 2;
          end
        end
      end
      if (setNow) mPend = 1;
      else if (clr_int_pulse_i) mPend = 0;
    end
  end

  // Compare process and memory responder, both acting mid-cycle.
  always @(negedge ACLK) begin
    txn_t t;
    if (!memInit) begin
      for (int i = 0; i < 1024; i++) mem[i] = $urandom;
      memInit = 1;
    end
    checkOutput("busy", status_busy_o, mPhase != 0);
    checkOutput("int_pending", status_int_pending_o, mPend);
    checkOutput("int_o", int_o, mPend & int_en_i);
    if (mPhase == 0) checkOutput("req_when_idle", mem_req_o, 1'b0);
    if (status_busy_o) busyCycles++;
    if (mem_req_o) reqCycles++;
    if (mem_req_o && outstanding) checkOutput("single_outstanding", 1'b1, 1'b0);

    mem_gnt_i = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i = $urandom;
    if (outstanding) begin
      rvCnt--;
      if (rvCnt == 0) begin
        mem_rvalid_i = 1'b1;
        if (!lastWasWrite) mem_rdata_i = respData;
        outstanding = 0;
      end
    end
    if (!mem_req_o) begin
      haveReq = 0;
    end else if (!outstanding) begin
      if (!haveReq) begin
        haveReq = 1;
        capReq = {mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o};
        gntWait = $urandom_range(0, gntMax);
      end else begin
        checkOutput("req_stable", {mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o}, capReq);
      end
      if (gntWait == 0) begin
        mem_gnt_i = 1'b1;
        haveReq = 0;
        outstanding = 1;
        lastWasWrite = mem_we_o;
        rvCnt = $urandom_range(rvMin, rvMax);
        if (expQ.size() == 0) begin
          checkOutput("unexpected_req", 1'b1, 1'b0);
        end else begin
          t = expQ.pop_front();
          checkOutput("txn_addr", mem_addr_o, t.addr);
          checkOutput("txn_we", mem_we_o, t.we);
          checkOutput("txn_be", mem_be_o, t.be);
          if (t.we) checkOutput("txn_wdata", mem_wdata_o, t.wdata);
        end
        if (mem_we_o) begin
          for (int b = 0; b < 4; b++)
            if (mem_be_o[b]) mem[mem_addr_o[11:2]][8*b +: 8] = mem_wdata_o[8*b +: 8];
          numWrites++;
          lastWrAddr = mem_addr_o;
          lastWrBe = mem_be_o;
        end else begin
          respData = mem[mem_addr_o[11:2]];
          numReads++;
          lastRdAddr = mem_addr_o;
        end
      end else begin
        gntWait--;
      end
    end
  end

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic pulseTrigger(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n);
    src_addr_i = s;
    dst_addr_i = d;
    size_i = n;
    trigger_pulse_i = 1'b1;
    tick();
    trigger_pulse_i = 1'b0;
  endtask

  int baseReads, baseWrites, baseBusy, baseReq;

  task automatic applyStimulus(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n);
    baseReads = numReads;
    baseWrites = numWrites;
    baseBusy = busyCycles;
    baseReq = reqCycles;
    pulseTrigger(s, d, n);
  endtask

  task automatic pulseClear();
    clr_int_pulse_i = 1'b1;
    tick();
    clr_int_pulse_i = 1'b0;
  endtask

  task automatic waitIdle();
    int k;
    k = 0;
    while ((mPhase != 0 || status_busy_o) && k < 3000) begin
      tick();
      k++;
    end
    if (k >= 3000) checkOutput("idle_timeout", 1'b1, 1'b0);
  endtask

  task automatic checkMemory();
    logic [31:0] a;
    for (int i = 0; i < mWords && i < 64; i++) begin
      a = mDst + 32'(4 * i);
      checkOutput("mem_word", mem[a[11:2]], expDst[i]);
    end
  endtask

  initial begin
    int k;
    repeat (3) tick();
    checkOutput("reset_busy", status_busy_o, 1'b0);
    checkOutput("reset_pending", status_int_pending_o, 1'b0);
    checkOutput("reset_req", mem_req_o, 1'b0);
    ARESET = 1'b0;
    tick();

    // Zero-wait two-word copy.
    int_en_i = 1'b1;
    applyStimulus(32'h100, 32'h200, 16'd8);
    waitIdle();
    checkMemory();
    checkOutput("t1_busy_cycles", busyCycles - baseBusy, 9);
    checkOutput("t1_reads", numReads - baseReads, 2);
    checkOutput("t1_writes", numWrites - baseWrites, 2);
    checkOutput("t1_last_rd_addr", lastRdAddr, 32'h104);
    checkOutput("t1_last_wr_addr", lastWrAddr, 32'h204);
    checkOutput("t1_last_be", lastWrBe, 4'b1111);
    checkOutput("t1_pending", status_int_pending_o, 1'b1);
    checkOutput("t1_int_on", int_o, 1'b1);
    int_en_i = 1'b0;
    #1;
    checkOutput("t1_int_off", int_o, 1'b0);

    // Partial tail word.
    pulseClear();
    applyStimulus(32'h340, 32'h600, 16'd6);
    waitIdle();
    checkMemory();
    checkOutput("t2_writes", numWrites - baseWrites, 2);
    checkOutput("t2_last_be", lastWrBe, 4'b0011);

    // Zero-length copy.
    pulseClear();
    applyStimulus(32'h40, 32'h80, 16'd0);
    waitIdle();
    checkOutput("t3_req_cycles", reqCycles - baseReq, 0);
    checkOutput("t3_busy_cycles", busyCycles - baseBusy, 1);
    checkOutput("t3_pending", status_int_pending_o, 1'b1);

    // Trigger while busy must not disturb the running copy.
    gntMax = 3; rvMin = 1; rvMax = 4;
    applyStimulus(32'h400, 32'h900, 16'd20);
    repeat (5) tick();
    pulseTrigger(32'h0, 32'hF00, 16'd4);
    waitIdle();
    checkMemory();
    checkOutput("t4_writes", numWrites - baseWrites, 5);

    // Clear on the completion edge loses to the set; a later clear works.
    pulseClear();
    applyStimulus(32'h500, 32'hA00, 16'd4);
    k = 0;
    while (mPhase != 2 && k < 500) begin tick(); k++; end
    if (k >= 500) checkOutput("t5_done_timeout", 1'b1, 1'b0);
    pulseClear();
    checkOutput("t5_set_wins", status_int_pending_o, 1'b1);
    pulseClear();
    checkOutput("t5_clear_alone", status_int_pending_o, 1'b0);

    // Reset while a write response is still outstanding.
    applyStimulus(32'h600, 32'hB00, 16'd12);
    k = 0;
    while (!(outstanding && lastWasWrite) && k < 500) begin tick(); k++; end
    if (k >= 500) checkOutput("t6_wr_wait_timeout", 1'b1, 1'b0);
    ARESET = 1'b1;
    tick();
    checkOutput("t6_busy", status_busy_o, 1'b0);
    checkOutput("t6_pending", status_int_pending_o, 1'b0);
    checkOutput("t6_int", int_o, 1'b0);
    checkOutput("t6_req", mem_req_o, 1'b0);
    checkOutput("t6_fields", {mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o}, 69'd0);
    ARESET = 1'b0;
    k = 0;
    while ((outstanding || mem_rvalid_i) && k < 50) begin tick(); k++; end
    repeat (2) tick();
    checkOutput("t6_late_rvalid", status_busy_o, 1'b0);
    applyStimulus(32'h680, 32'hC00, 16'd16);
    waitIdle();
    checkMemory();

    // Source address wraps past the top of the address space.
    applyStimulus(32'hFFFF_FFFC, 32'hD00, 16'd8);
    waitIdle();
    checkMemory();
    checkOutput("t7_last_rd_addr", lastRdAddr, 32'h0);

    // Randomized copies.
    for (int n = 0; n < 12; n++) begin
      int_en_i = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) pulseClear();
      applyStimulus({22'd0, 8'($urandom_range(0, 255)), 2'($urandom_range(0, 3))},
                    32'h800 + {22'd0, 8'($urandom_range(0, 255)), 2'($urandom_range(0, 3))},
                    16'($urandom_range(0, 64)));
      waitIdle();
      checkMemory();
    end

`ifdef UP_COPY_ABORT_EN
    // Abort while the second read of a four-word copy is outstanding.
    gntMax = 0; rvMin = 3; rvMax = 3;
    pulseClear();
    applyStimulus(32'h100, 32'h880, 16'd16);
    k = 0;
    while (!(numWrites - baseWrites == 1 && outstanding && !lastWasWrite) && k < 500) begin tick(); k++; end
    if (k >= 500) checkOutput("t8_rd_wait_timeout", 1'b1, 1'b0);
    abort_pulse_i = 1'b1;
    tick();
    abort_pulse_i = 1'b0;
    waitIdle();
    checkOutput("t8_reads", numReads - baseReads, 2);
    checkOutput("t8_writes", numWrites - baseWrites, 1);
    checkOutput("t8_pending", status_int_pending_o, 1'b1);
`endif

    repeat (2) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
